// File: rtl/selector_41.sv
// Registered 4-to-1 channel selector with one-hot channel indication and a
// sticky valid flag; all outputs come straight from flops.
module selector_41 #(
  parameter int unsigned           WIDTH   = 4,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iC0,
  input  logic [WIDTH-1:0] iC1,
  input  logic [WIDTH-1:0] iC2,
  input  logic [WIDTH-1:0] iC3,
  input  logic             iS0,
  input  logic             iS1,
  input  logic             iEn,
  output logic [WIDTH-1:0] oZ,
  output logic [3:0]       oSel,
  output logic             oValid
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] z_q, z_d;
  logic [3:0]       sel_q, sel_d;
  logic             valid_q, valid_d;

  assign sel = {iS1, iS0};

  always_comb begin
    z_d     = z_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (iEn) begin
      valid_d = 1'b1;
      case (sel)
        2'b00: begin z_d = iC0; sel_d = 4'b0001; end
        2'b01: begin z_d = iC1; sel_d = 4'b0010; end
        2'b10: begin z_d = iC2; sel_d = 4'b0100; end
        default: begin z_d = iC3; sel_d = 4'b1000; end
      endcase
    end
  end

  // Reset wins over enable so a mid-stream reset always clears the channel state.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      z_q     <= RST_VAL;
      sel_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      z_q     <= z_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign oZ     = z_q;
  assign oSel   = sel_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_selector_41.sv
// Directed and randomized bench for selector_41 against an array-indexed
// reference model of the registered channel selector.
module tb_selector_41;

  logic       clk = 1'b0;
  logic       rst, en, s0, s1;
  logic [3:0] c0, c1, c2, c3;
  logic [3:0] z, sel_oh;
  logic       valid;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] m_z, m_sel;
  logic       m_valid;
  bit         m_ok = 1'b0;

  always #5 clk = ~clk;

  selector_41 #(.WIDTH(4), .RST_VAL(4'b0000)) dut (
    .iClk(clk), .iRst(rst),
    .iC0(c0), .iC1(c1), .iC2(c2), .iC3(c3),
    .iS0(s0), .iS1(s1), .iEn(en),
    .oZ(z), .oSel(sel_oh), .oValid(valid)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_z"}, z, m_z);
    check({tag, "_sel"}, sel_oh, m_sel);
    check({tag, "_valid"}, {3'b000, valid}, {3'b000, m_valid});
  endtask

  // One cycle: scribble junk on the inputs, confirm outputs ignore it, then
  // present the real values and check the state one edge later.
  task automatic apply(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d, input logic [1:0] s,
                       input logic e, input logic r);
    logic [3:0] ch [4];
    @(negedge clk);
    rst = r; en = $urandom_range(0, 1) != 0; {s1, s0} = 2'($urandom);
    c0 = 4'($urandom); c1 = 4'($urandom); c2 = 4'($urandom); c3 = 4'($urandom);
    #1;
    if (m_ok) check_all({tag, "_midcycle"});
    #1;
    rst = r; en = e; {s1, s0} = s;
    c0 = a; c1 = b; c2 = c; c3 = d;
    vectors++;
    @(posedge clk);
    if (r) begin
      m_z = 4'b0000; m_sel = 4'b0000; m_valid = 1'b0; m_ok = 1'b1;
    end else if (e) begin
      ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = d;
      m_z = ch[s]; m_sel = 4'(1) << s; m_valid = 1'b1;
    end
    #1;
    if (m_ok) check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; s0 = 1'b0; s1 = 1'b0;
    c0 = '0; c1 = '0; c2 = '0; c3 = '0;

    repeat (2) apply("reset", 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                     2'($urandom), 1'b1, 1'b1);

    for (int i = 0; i < 4; i++)
      apply("sweep", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'(i), 1'b1, 1'b0);

    for (int i = 0; i < 4; i++)
      apply("dupzero", 4'b0001, 4'b0010, 4'b0000, 4'b0000, 2'(i), 1'b1, 1'b0);

    apply("hold_cap", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'b11, 1'b1, 1'b0);
    repeat (3) apply("hold", 4'b0001, 4'b0010, 4'b0100, 4'b1111, 2'b00, 1'b0, 1'b0);
    apply("hold_release", 4'b0001, 4'b0010, 4'b0100, 4'b1111, 2'b00, 1'b1, 1'b0);

    apply("rstprio_pre", 4'b0011, 4'b0110, 4'b1100, 4'b1001, 2'b01, 1'b1, 1'b0);
    apply("rstprio", 4'b0011, 4'b0110, 4'b1100, 4'b1001, 2'b01, 1'b1, 1'b1);
    apply("rstprio_post", 4'b0011, 4'b0110, 4'b1100, 4'b1001, 2'b01, 1'b1, 1'b0);

    apply("samecyc_pre", 4'b0001, 4'b0010, 4'b0100, 4'b1000, 2'b00, 1'b1, 1'b0);
    apply("samecyc", 4'b0001, 4'b0010, 4'b1010, 4'b1000, 2'b10, 1'b1, 1'b0);

    for (int i = 0; i < 300; i++)
      apply("random", 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
            2'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/selector_41.md
Name: selector_41

Overview:
- Registered 4-to-1 multiplexer for WIDTH-bit data words.
- A 2-bit select {iS1,iS0} picks one of four input channels. The chosen word is captured into an output register on the next clock edge.
- Used as a generic channel selector in datapaths where a registered, glitch-free mux output is needed.
- Also provides a one-hot indication of the selected channel and a valid flag.

Parameters:
- WIDTH, 4, bit width of each data channel and of oZ.
- RST_VAL, 0, value loaded into oZ on reset (WIDTH bits, zero-extended).

Ports:
- iClk  input  1  system clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iC0  input  WIDTH  data channel 0.
- iC1  input  WIDTH  data channel 1.
- iC2  input  WIDTH  data channel 2.
- iC3  input  WIDTH  data channel 3.
- iS0  input  1  select bit 0 (LSB).
- iS1  input  1  select bit 1 (MSB).
- iEn  input  1  capture enable; when low, outputs hold.
- oZ  output  WIDTH  registered selected data word.
- oSel  output  4  registered one-hot of the captured channel (bit n = channel n).
- oValid  output  1  high once at least one capture has occurred since reset.

Behaviour:
- Select decode, sel = {iS1,iS0}:
  - 2'b00 -> iC0
  - 2'b01 -> iC1
  - 2'b10 -> iC2
  - 2'b11 -> iC3
- Rising iClk with iRst=1:
  - oZ <= RST_VAL, oSel <= 4'b0000, oValid <= 0.
  - Reset has priority over iEn.
- Rising iClk with iRst=0 and iEn=1:
  - oZ <= selected channel, oSel <= one-hot(sel), oValid <= 1.
- Rising iClk with iRst=0 and iEn=0:
  - oZ, oSel and oValid hold their previous values.
- Latency: exactly one clock from a select/data change to oZ. No combinational path from inputs to outputs.
- Data is passed bit-exact; no arithmetic, sign handling or width conversion.
- Inputs are sampled only at the clock edge. Changes between edges have no effect, and changing select and data in the same cycle uses the new values.
- oSel is always one-hot after the first capture, and is all-zero only while oValid=0.
- Reset asserted mid-operation clears state on the next edge regardless of iEn or select. After deassertion, the first enabled edge captures normally.
- X/Z on select is not supported. Inputs must be driven to known values whenever iEn=1.

Test Plan:
- Reset: iRst=1 for 2 cycles with arbitrary inputs -> oZ=4'b0000, oSel=4'b0000, oValid=0.
- Select sweep: iC0=4'b0001, iC1=4'b0010, iC2=4'b0100, iC3=4'b1000, iEn=1; apply {iS1,iS0}=00, 01, 10, 11 in successive cycles -> one cycle later oZ=0001/0010/0100/1000 with oSel=0001/0010/0100/1000 respectively; oValid=1 from the first capture.
- Duplicate/zero data: iC0=4'b0001, iC1=4'b0010, iC2=4'b0000, iC3=4'b0000 -> sel 00->0001, 01->0010, 10->0000 (oSel=0100), 11->0000 (oSel=1000). This confirms oSel tracks the channel independent of data.
- Hold: capture sel=11 (oZ=1000), then iEn=0 while changing sel to 00 and iC3 to 4'b1111 for 3 cycles -> oZ stays 1000 and oSel stays 1000; re-assert iEn -> oZ=0001 the next cycle.
- Reset priority: iEn=1, sel=01, assert iRst for one edge mid-stream -> oZ=0000, oValid=0 after that edge; on deassertion the next edge gives oZ=iC1.
- Same-cycle change: change sel 00->10 and iC2 4'b0100->4'b1010 together -> the next edge gives oZ=1010.
